// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Grants one burst at a time; a burst ends on req_last or after MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int BW        = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  full,
    input  logic                  almost_full,
    output logic                  fifo_en,
    output logic                  fifo_wra,
    output logic [WIDTH-1:0]      fifo_din,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_nx;
    logic [NREQ-1:0] grant_nx;
    logic [PW-1:0]   rr_ptr, rr_nx;
    logic [BW-1:0]   cnt, cnt_nx, cnt_inc;
    logic [PW-1:0]   sel, idx;
    logic            sel_ok;
    logic            g_valid, g_last, xfer, burst_end;
    logic [WIDTH-1:0] g_data;

    // Iterate from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(rr_ptr) + i) % NREQ);
            if (req_valid[idx]) begin
                sel    = idx;
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        g_valid = |(req_valid & grant);
        g_last  = |(req_last & grant);
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) g_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign xfer      = (state == XFER) && g_valid && !full;
    assign cnt_inc   = cnt + 1'b1;
    assign burst_end = xfer && (g_last || (cnt_inc == BW'(MAX_BURST)));

    assign req_ready = ((state == XFER) && !full) ? grant : '0;
    assign fifo_en   = xfer;
    assign fifo_wra  = xfer;
    assign fifo_din  = xfer ? g_data : '0;
    assign busy      = (state == XFER);

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        rr_nx    = rr_ptr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (sel_ok && !almost_full) begin
                    state_nx = XFER;
                    grant_nx = NREQ'(1) << sel;
                    cnt_nx   = '0;
                    rr_nx    = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                end
            end
            XFER: begin
                if (xfer) begin
                    cnt_nx = cnt_inc;
                    if (burst_end) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= rr_nx;
            cnt    <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin order, burst limits, stalls,
// almost_full gating and mid-burst reset, checked with immediate assertions.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        full, almost_full, fifo_en, fifo_wra, busy;
    logic [7:0]  fifo_din;

    logic [3:0]  act;
    int          last_len [4];
    logic [7:0]  wc [4];
    logic        wc_clr;
    int          n_cmp = 0;
    int          n_err = 0;
    int          nwr = 0;

    fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(16), .BW(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .full(full),
        .almost_full(almost_full), .fifo_en(fifo_en), .fifo_wra(fifo_wra),
        .fifo_din(fifo_din), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Requester i sends words tagged {i, word counter}; last every last_len words.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = act[i];
            req_data[i*8 +: 8]  = 8'(i * 16) + {4'b0, wc[i][3:0]};
            req_last[i]         = (last_len[i] != 0) &&
                                  ((int'(wc[i]) % last_len[i]) == last_len[i] - 1);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wc_clr) wc[i] <= 8'd0;
            else if (req_valid[i] && req_ready[i]) wc[i] <= wc[i] + 8'd1;
        end
        if (fifo_en) nwr <= nwr + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, " grant"}, 32'(grant), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " fifo_en"}, 32'(fifo_en), 32'h0);
        chk({tag, " req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, " fifo_din"}, 32'(fifo_din), 32'h0);
    endtask

    task automatic chk_word(input string tag, input int g, input int nib);
        #1;
        chk({tag, " grant"}, 32'(grant), 32'(1 << g));
        chk({tag, " busy"}, 32'(busy), 32'h1);
        chk({tag, " fifo_en"}, 32'(fifo_en), 32'h1);
        chk({tag, " fifo_wra"}, 32'(fifo_wra), 32'h1);
        chk({tag, " req_ready"}, 32'(req_ready), 32'(1 << g));
        chk({tag, " fifo_din"}, 32'(fifo_din), 32'(g * 16 + nib));
    endtask

    task automatic chk_stall(input string tag, input int g, input logic [3:0] rdy);
        #1;
        chk({tag, " grant"}, 32'(grant), 32'(1 << g));
        chk({tag, " busy"}, 32'(busy), 32'h1);
        chk({tag, " fifo_en"}, 32'(fifo_en), 32'h0);
        chk({tag, " fifo_wra"}, 32'(fifo_wra), 32'h0);
        chk({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, " fifo_din"}, 32'(fifo_din), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst = 1'b1; full = 1'b0; almost_full = 1'b0; act = 4'h0; wc_clr = 1'b1;
        for (int i = 0; i < 4; i++) last_len[i] = 0;
        tick(); tick();
        rst = 1'b0; wc_clr = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            chk_idle("reset_idle");
            tick();
        end

        // All four requesters, 3-word bursts: grants 0,1,2,3,0 with one bubble
        for (int i = 0; i < 4; i++) last_len[i] = 3;
        act = 4'hF; wc_clr = 1'b1; n0 = nwr;
        for (int k = 0; k < 5; k++) begin
            chk_idle("rr_bubble");
            tick();
            wc_clr = 1'b0;
            for (int w = 0; w < 3; w++) begin
                chk_word("rr_word", k % 4, w + 3 * (k / 4));
                tick();
            end
        end
        act = 4'h0;
        chk("rr_write_count", 32'(nwr - n0), 32'd15);

        // Requester 2 alone, no last: MAX_BURST words, then re-granted
        for (int i = 0; i < 4; i++) last_len[i] = 0;
        act = 4'b0100; wc_clr = 1'b1; n0 = nwr;
        chk_idle("max_pre");
        tick();
        wc_clr = 1'b0;
        for (int w = 0; w < 16; w++) begin
            chk_word("max_word", 2, w);
            tick();
        end
        chk("max_write_count", 32'(nwr - n0), 32'd16);
        chk_idle("max_bubble");
        tick();
        chk("max_regrant", 32'(grant), 32'b0100);

        // Valid drops: grant held, nothing written
        act = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            chk_stall("vdrop", 2, 4'b0100);
            tick();
        end

        // Second burst ends by last and MAX_BURST together; full stalls after word 4
        act = 4'b0100; last_len[2] = 16; n0 = nwr;
        for (int w = 0; w < 4; w++) begin
            chk_word("stall_pre", 2, w);
            tick();
        end
        full = 1'b1; almost_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk_stall("stall", 2, 4'b0000);
            tick();
        end
        full = 1'b0; almost_full = 1'b0;
        for (int w = 4; w < 16; w++) begin
            chk_word("stall_post", 2, w);
            tick();
        end
        act = 4'h0;
        chk("stall_write_count", 32'(nwr - n0), 32'd16);
        chk_idle("coincide_end");
        tick();
        chk_idle("coincide_after");

        // almost_full gates new grants in IDLE (rr_ptr now 3)
        for (int i = 0; i < 4; i++) last_len[i] = 1;
        almost_full = 1'b1; act = 4'b0011; wc_clr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_idle("afull_hold");
            tick();
            wc_clr = 1'b0;
        end
        almost_full = 1'b0;
        chk_idle("afull_drop");
        tick();
        chk_word("afull_grant", 0, 0);
        tick();
        last_len[1] = 0;
        chk_idle("afull_bubble");
        tick();

        // Mid-burst reset during word 2 of requester 1
        act = 4'b0010;
        chk_word("rst_w1", 1, 0);
        tick();
        rst = 1'b1;
        chk_word("rst_w2", 1, 1);
        tick();
        rst = 1'b0; act = 4'hF;
        chk_idle("rst_after");
        tick();
        chk("rst_rrptr_grant", 32'(grant), 32'b0001);
        chk("rst_rrptr_busy", 32'(busy), 32'h1);
        act = 4'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
